// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 unit: register indices, field positions,
// exception codes, the fixed addresses and the EXL-based state encoding.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE_BIT      = 0;
    localparam int SR_EXL_BIT     = 1;
    localparam int SR_IM_LSB      = 10;
    localparam int SR_IM_MSB      = 15;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_EXC_MSB  = 6;
    localparam int CAUSE_IP_LSB   = 10;
    localparam int CAUSE_IP_MSB   = 15;
    localparam int CAUSE_BD_BIT   = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] PRID         = 32'h2015_1122;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // The FSM state is SR.EXL itself, so the encoding must stay 0/1.
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_t;

    // EPC always holds a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bundle. The pipeline side is the master; cp0_unit is the slave.
interface cp0_unit_if;

    logic [31:0] pc_M;
    logic        bd_M;
    logic        exc_valid_M;
    logic [4:0]  exc_code_M;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_M;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        exl;

    modport master (
        output pc_M, bd_M, exc_valid_M, exc_code_M, hw_int,
               cp0_we, cp0_addr, cp0_wdata, eret_M,
        input  cp0_rdata, exc_req, redirect_pc, epc, exl
    );

    modport slave (
        input  pc_M, bd_M, exc_valid_M, exc_code_M, hw_int,
               cp0_we, cp0_addr, cp0_wdata, eret_M,
        output cp0_rdata, exc_req, redirect_pc, epc, exl
    );

endinterface

// File: rtl/cp0_req_arb.sv
// Interrupt/exception arbitration at the M stage. Purely combinational;
// interrupts beat synchronous exceptions and report ExcCode INT.
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic       ie,
    input  logic       exl,
    input  logic [5:0] im,
    input  logic [5:0] hw_int,
    input  logic       exc_valid,
    input  logic [4:0] exc_code,
    output logic       exc_req,
    output logic [4:0] exc_code_sel
);

    logic int_p;
    logic exc_p;

    assign int_p        = ie & ~exl & (|(hw_int & im));
    assign exc_p        = exc_valid & ~exl;
    assign exc_req      = int_p | exc_p;
    assign exc_code_sel = int_p ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId, plus the exception/eret redirect
// that feeds the PC register.
// Optional feature: define CP0_BD_EN to record branch-delay-slot exceptions
// (Cause.BD set and EPC pointing at the branch).
//
// state      | meaning
// ST_NORMAL  | SR.EXL=0, interrupts and exceptions may be taken
// ST_HANDLER | SR.EXL=1, inside the handler, new requests are blocked
module cp0_unit
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    cp0_unit_if.slave   bus
);

    cp0_state_t  state;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic        cause_bd;
    logic [31:0] epc_q;

    logic        exl;
    logic        req;
    logic [4:0]  code_sel;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] pc_aligned;

    assign exl        = (state == ST_HANDLER);
    assign pc_aligned = word_align(bus.pc_M);
    assign sr_val     = {16'b0, sr_im, 8'b0, exl, sr_ie};
    assign cause_val  = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};

    cp0_req_arb u_arb (
        .ie           (sr_ie),
        .exl          (exl),
        .im           (sr_im),
        .hw_int       (bus.hw_int),
        .exc_valid    (bus.exc_valid_M),
        .exc_code     (bus.exc_code_M),
        .exc_req      (req),
        .exc_code_sel (code_sel)
    );

    // FSM plus register file: a taken request overrides mtc0 and eret in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_NORMAL;
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            cause_bd  <= 1'b0;
            epc_q     <= '0;
        end else begin
            cause_ip <= bus.hw_int;
            if (req) begin
                state     <= ST_HANDLER;
                cause_exc <= code_sel;
`ifdef CP0_BD_EN
                if (bus.bd_M) begin
                    cause_bd <= 1'b1;
                    epc_q    <= pc_aligned - 32'd4;
                end else begin
                    cause_bd <= 1'b0;
                    epc_q    <= pc_aligned;
                end
`else
                cause_bd <= 1'b0;
                epc_q    <= pc_aligned;
`endif
            end else begin
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        REG_SR: begin
                            sr_im <= bus.cp0_wdata[SR_IM_MSB:SR_IM_LSB];
                            sr_ie <= bus.cp0_wdata[SR_IE_BIT];
                            state <= bus.cp0_wdata[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
                        end
                        REG_EPC: epc_q <= bus.cp0_wdata;
                        default: ;
                    endcase
                end
                // eret has the last word on EXL when it shares a cycle with an SR write.
                if (bus.eret_M) begin
                    state <= ST_NORMAL;
                end
            end
        end
    end

    // mfc0 read mux; reads see pre-edge register values.
    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            REG_SR:    bus.cp0_rdata = sr_val;
            REG_CAUSE: bus.cp0_rdata = cause_val;
            REG_EPC:   bus.cp0_rdata = epc_q;
            REG_PRID:  bus.cp0_rdata = PRID;
            default:   bus.cp0_rdata = '0;
        endcase
    end

    // Redirect: handler entry wins over eret.
    always_comb begin
        bus.redirect_pc = '0;
        if (req) begin
            bus.redirect_pc = HANDLER_ADDR;
        end else if (bus.eret_M) begin
            bus.redirect_pc = epc_q;
        end
    end

    assign bus.exc_req = req;
    assign bus.epc     = epc_q;
    assign bus.exl     = exl;

endmodule
